// File: rtl/mem_wb_stage.sv
// Memory-access stage with MEM/WB register; issues data-memory requests over a req/ack handshake.
// Optional access timeout enabled by defining MEM_TIMEOUT_EN.
module mem_wb_stage #(
    parameter int DATA_W         = 32,
    parameter int ADDR_W         = 16,
    parameter int REG_W          = 3,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              MEM_regwrite,
    input  logic              MEM_memtoreg,
    input  logic              MEM_memread,
    input  logic              MEM_memwrite,
    input  logic [DATA_W-1:0] MEM_out,
    input  logic [DATA_W-1:0] MEM_wdata,
    input  logic [REG_W-1:0]  MEM_rd,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_ack,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              mem_stall,
    output logic              WB_regwrite,
    output logic [REG_W-1:0]  WB_rd,
    output logic [DATA_W-1:0] WB_result,
    output logic              mem_err
);

    localparam logic ST_IDLE   = 1'b0;
    localparam logic ST_ACCESS = 1'b1;

    logic              state_q, state_d;
    logic              mem_op;
    logic              timeout;
    logic              wb_load;
    logic              wb_bubble;
    logic              capture;
    logic [DATA_W-1:0] wb_result_d;

    assign mem_op   = MEM_memread | MEM_memwrite;
    assign dmem_req = (state_q == ST_ACCESS);

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q;
    logic             err_q;

    // Fires in the last allowed ACCESS cycle when no ack arrives.
    assign timeout = (state_q == ST_ACCESS) && !dmem_ack &&
                     (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    assign mem_err = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            if (state_q == ST_ACCESS) begin
                cnt_q <= cnt_q + 1'b1;
            end else begin
                cnt_q <= '0;
            end
            if (timeout) begin
                err_q <= 1'b1;
            end
        end
    end
`else
    assign timeout = 1'b0;
    assign mem_err = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        mem_stall = 1'b0;
        wb_load   = 1'b0;
        wb_bubble = 1'b0;
        capture   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (mem_op) begin
                    mem_stall = 1'b1;
                    wb_bubble = 1'b1;
                    capture   = 1'b1;
                    state_d   = ST_ACCESS;
                end else begin
                    wb_load = 1'b1;
                end
            end
            default: begin
                if (dmem_ack) begin
                    wb_load = 1'b1;
                    state_d = ST_IDLE;
                end else if (timeout) begin
                    wb_bubble = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    mem_stall = 1'b1;
                    wb_bubble = 1'b1;
                end
            end
        endcase
    end

    assign wb_result_d = ((state_q == ST_ACCESS) && MEM_memtoreg) ? dmem_rdata : MEM_out;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            dmem_we     <= 1'b0;
            dmem_addr   <= '0;
            dmem_wdata  <= '0;
            WB_regwrite <= 1'b0;
            WB_rd       <= '0;
            WB_result   <= '0;
        end else begin
            state_q <= state_d;
            // Load+store together is treated as a store.
            if (capture) begin
                dmem_we    <= MEM_memwrite;
                dmem_addr  <= MEM_out[ADDR_W-1:0];
                dmem_wdata <= MEM_wdata;
            end
            if (wb_load) begin
                WB_regwrite <= MEM_regwrite;
                WB_rd       <= MEM_rd;
                WB_result   <= wb_result_d;
            end else if (wb_bubble) begin
                WB_regwrite <= 1'b0;
            end
        end
    end

endmodule
